// File: rtl/alu_issue_pkg.sv
// Shared types and defaults for the ALU issue slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_issue_pkg;

    localparam int DEPTH_DEF   = 4;
    localparam int ALU_LAT_DEF = 2;
    localparam int TAG_W       = 4;

    typedef enum logic [1:0] {
        OPC_ARITH   = 2'b00,
        OPC_SHIFT   = 2'b01,
        OPC_NOP     = 2'b10,
        OPC_ILLEGAL = 2'b11
    } opclass_e;

    typedef struct packed {
        opclass_e         cls;
        logic [2:0]       op;
        logic [2:0]       opsel;
        logic [4:0]       shamt;
        logic [31:0]      src1;
        logic [31:0]      src2;
        logic [TAG_W-1:0] tag;
    } pkt_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// In-order packet buffer with DEPTH entries and wrap-bit pointers.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: full_o comes from registered pointers, so a pop never frees a slot in the same cycle.
module alu_issue_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  pkt_t push_dat_i,
    input  logic pop_i,
    output pkt_t head_dat_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    pkt_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop; the extra MSB tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers; reset empties the buffer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are don't-care until the write pointer covers them.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/alu_issue.sv
// Decodes incoming packets, buffers them in order and issues one per cycle to the ALU; optional illegal counter under ALU_ISSUE_ILLEGAL_CNT_EN.
// Latency: accept at edge k -> issue outputs after edge k+1; res_valid/res_tag ALU_LAT edges after issue.
// Backpressure: in_ready drops when the buffer is full; stall holds the head and issues bubbles.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    input  logic [2:0]       in_op,
    input  logic [2:0]       in_opsel,
    input  logic [4:0]       in_shamt,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             stall,
    output logic             enable_arith,
    output logic             enable_shift,
    output logic [2:0]       operation,
    output logic [2:0]       opselect,
    output logic [4:0]       shift_number,
    output logic [31:0]      aluin1,
    output logic [31:0]      aluin2,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    ,
    output logic [7:0]       illegal_cnt
`endif
);

    pkt_t in_pkt;
    pkt_t head_pkt;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic is_illegal;
    logic push;
    logic pop;

    assign in_pkt.cls   = opclass_e'(in_class);
    assign in_pkt.op    = in_op;
    assign in_pkt.opsel = in_opsel;
    assign in_pkt.shamt = in_shamt;
    assign in_pkt.src1  = in_src1;
    assign in_pkt.src2  = in_src2;
    assign in_pkt.tag   = in_tag;

    // Ready is forced high while reset is held so upstream sees a clean empty buffer.
    assign in_ready   = !fifo_full || !reset;
    assign accept     = in_valid && in_ready && reset;
    assign is_illegal = (in_pkt.cls == OPC_ILLEGAL);
    assign push       = accept && !is_illegal;
    assign pop        = !stall && !fifo_empty;

    alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (in_pkt),
        .pop_i      (pop),
        .head_dat_o (head_pkt),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    logic             en_arith_q, en_arith_d;
    logic             en_shift_q, en_shift_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       opsel_q, opsel_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [31:0]      src1_q, src1_d;
    logic [31:0]      src2_q, src2_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;

    // Issue stage: a pop loads the head; otherwise a bubble with operands held.
    always_comb begin
        en_arith_d = 1'b0;
        en_shift_d = 1'b0;
        op_d       = op_q;
        opsel_d    = opsel_q;
        shamt_d    = shamt_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        iss_tag_d  = iss_tag_q;
        if (pop) begin
            en_arith_d = (head_pkt.cls == OPC_ARITH);
            en_shift_d = (head_pkt.cls == OPC_SHIFT);
            op_d       = head_pkt.op;
            opsel_d    = head_pkt.opsel;
            shamt_d    = head_pkt.shamt;
            src1_d     = head_pkt.src1;
            src2_d     = head_pkt.src2;
            iss_tag_d  = head_pkt.tag;
        end
    end

    // Issue registers driving the ALU control and operand outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            en_arith_q <= 1'b0;
            en_shift_q <= 1'b0;
            op_q       <= '0;
            opsel_q    <= '0;
            shamt_q    <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            iss_tag_q  <= '0;
        end else begin
            en_arith_q <= en_arith_d;
            en_shift_q <= en_shift_d;
            op_q       <= op_d;
            opsel_q    <= opsel_d;
            shamt_q    <= shamt_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            iss_tag_q  <= iss_tag_d;
        end
    end

    assign enable_arith = en_arith_q;
    assign enable_shift = en_shift_q;
    assign operation    = op_q;
    assign opselect     = opsel_q;
    assign shift_number = shamt_q;
    assign aluin1       = src1_q;
    assign aluin2       = src2_q;

    logic [ALU_LAT-1:0] res_vld_q, res_vld_d;
    logic [TAG_W-1:0]   res_tag_q [ALU_LAT];
    logic [TAG_W-1:0]   res_tag_d [ALU_LAT];

    // Result pipeline shadows the ALU: a real (arith/shift) issue emerges ALU_LAT cycles later.
    always_comb begin
        res_vld_d[0] = en_arith_q || en_shift_q;
        res_tag_d[0] = iss_tag_q;
        for (int i = 1; i < ALU_LAT; i++) begin
            res_vld_d[i] = res_vld_q[i-1];
            res_tag_d[i] = res_tag_q[i-1];
        end
    end

    // Result pipeline registers; reset drops everything in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            res_vld_q <= '0;
            for (int i = 0; i < ALU_LAT; i++) res_tag_q[i] <= '0;
        end else begin
            res_vld_q <= res_vld_d;
            for (int i = 0; i < ALU_LAT; i++) res_tag_q[i] <= res_tag_d[i];
        end
    end

    assign res_valid = res_vld_q[ALU_LAT-1];
    assign res_tag   = res_tag_q[ALU_LAT-1];

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    logic [7:0] ill_cnt_q, ill_cnt_d;

    // Count dropped illegal packets, saturating at all-ones.
    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (accept && is_illegal && (ill_cnt_q != 8'hFF)) ill_cnt_d = ill_cnt_q + 8'd1;
    end

    // Illegal counter register.
    always_ff @(posedge clock) begin
        if (!reset) ill_cnt_q <= '0;
        else        ill_cnt_q <= ill_cnt_d;
    end

    assign illegal_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Randomized and directed stimulus against a queue-based reference model with a decoupled scoreboard monitor.
// Latency: expected issue/result cycles are computed by the model from the edge a packet leaves the buffer.
// Backpressure: the model tracks buffer occupancy to decide acceptance and the expected in_ready.
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_class = '0;
    logic [2:0]  in_op = '0;
    logic [2:0]  in_opsel = '0;
    logic [4:0]  in_shamt = '0;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic [3:0]  in_tag = '0;
    logic        stall = 1'b0;
    logic        enable_arith, enable_shift;
    logic [2:0]  operation, opselect;
    logic [4:0]  shift_number;
    logic [31:0] aluin1, aluin2;
    logic        res_valid;
    logic [3:0]  res_tag;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    logic [7:0]  illegal_cnt;
`endif

    always #5 clock = ~clock;

    alu_issue #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_class     (in_class),
        .in_op        (in_op),
        .in_opsel     (in_opsel),
        .in_shamt     (in_shamt),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .in_tag       (in_tag),
        .stall        (stall),
        .enable_arith (enable_arith),
        .enable_shift (enable_shift),
        .operation    (operation),
        .opselect     (opselect),
        .shift_number (shift_number),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .res_valid    (res_valid),
        .res_tag      (res_tag)
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt  (illegal_cnt)
`endif
    );

    typedef struct {
        pkt_t p;
        int   cyc;
    } iss_t;

    typedef struct {
        logic [3:0] tag;
        int         cyc;
    } res_t;

    pkt_t mq[$];
    iss_t exp_iss[$];
    res_t exp_res[$];
    int   cyc = 0;
    int   ill_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a plain queue of buffered packets, updated at each clock edge.
    always @(posedge clock) begin
        int   n;
        pkt_t p;
        cyc++;
        if (!reset) begin
            mq.delete();
            exp_iss.delete();
            exp_res.delete();
            ill_cnt = 0;
        end else begin
            n = mq.size();
            if (!stall && n > 0) begin
                p = mq.pop_front();
                if (p.cls != OPC_NOP) begin
                    exp_iss.push_back('{p, cyc});
                    exp_res.push_back('{p.tag, cyc + LAT});
                end
            end
            if (in_valid && n < DEPTH) begin
                if (in_class == 2'b11) begin
                    ill_cnt = (ill_cnt < 255) ? ill_cnt + 1 : 255;
                end else begin
                    p.cls   = opclass_e'(in_class);
                    p.op    = in_op;
                    p.opsel = in_opsel;
                    p.shamt = in_shamt;
                    p.src1  = in_src1;
                    p.src2  = in_src2;
                    p.tag   = in_tag;
                    mq.push_back(p);
                end
            end
        end
    end

    // Scoreboard monitor: compares DUT outputs on the falling edge against the queued expectations.
    always @(negedge clock) begin
        iss_t e;
        res_t r;
        check("in_ready", in_ready, (!reset || mq.size() < DEPTH));
        check("enables_exclusive", enable_arith & enable_shift, 0);
        if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
            e = exp_iss.pop_front();
            check("enable_arith", enable_arith, e.p.cls == OPC_ARITH);
            check("enable_shift", enable_shift, e.p.cls == OPC_SHIFT);
            check("operation", operation, e.p.op);
            check("opselect", opselect, e.p.opsel);
            check("shift_number", shift_number, e.p.shamt);
            check("aluin1", aluin1, e.p.src1);
            check("aluin2", aluin2, e.p.src2);
        end else begin
            check("bubble_enables", {enable_arith, enable_shift}, 0);
        end
        if (exp_res.size() > 0 && exp_res[0].cyc == cyc) begin
            r = exp_res.pop_front();
            check("res_valid", res_valid, 1);
            check("res_tag", res_tag, r.tag);
        end else begin
            check("res_idle", res_valid, 0);
        end
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        check("illegal_cnt", illegal_cnt, ill_cnt);
`endif
    end

    task automatic drive(input logic v, input logic [1:0] cls, input logic [3:0] tag,
                         input logic st, input logic rst, input logic [2:0] op,
                         input logic [2:0] opsel, input logic [31:0] s1, input logic [31:0] s2);
        in_valid = v;
        in_class = cls;
        in_tag   = tag;
        stall    = st;
        reset    = rst;
        in_op    = op;
        in_opsel = opsel;
        in_src1  = s1;
        in_src2  = s2;
        in_shamt = s1[9:5];
        @(posedge clock);
        #2;
    endtask

    task automatic rdrive(input logic v, input logic [1:0] cls, input logic [3:0] tag,
                          input logic st, input logic rst);
        drive(v, cls, tag, st, rst, 3'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rdrive(0, 2'b00, 4'h0, 0, 1);
    endtask

    task automatic check_all_zero();
        check("rst_enable_arith", enable_arith, 0);
        check("rst_enable_shift", enable_shift, 0);
        check("rst_operation", operation, 0);
        check("rst_opselect", opselect, 0);
        check("rst_shift_number", shift_number, 0);
        check("rst_aluin1", aluin1, 0);
        check("rst_aluin2", aluin2, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        check("rst_illegal_cnt", illegal_cnt, 0);
`endif
    endtask

    initial begin
        // Power-up reset.
        rdrive(0, 2'b00, 4'h0, 0, 0);
        rdrive(0, 2'b00, 4'h0, 0, 0);
        check_all_zero();

        // Single arith packet.
        drive(1, 2'b00, 4'd3, 0, 1, 3'b000, 3'b001, 32'd5, 32'd7);
        idle(5);

        // Fill under stall, then one rejected extra, then release.
        for (int i = 0; i < 4; i++) rdrive(1, 2'b01, 4'(4 + i), 1, 1);
        rdrive(1, 2'b01, 4'd8, 1, 1);
        idle(8);

        // Illegal packet sandwiched between two arith packets.
        rdrive(1, 2'b00, 4'd1, 0, 1);
        rdrive(1, 2'b11, 4'd9, 0, 1);
        rdrive(1, 2'b00, 4'd2, 0, 1);
        idle(5);

        // Reset with three entries buffered and two in flight.
        for (int i = 0; i < 4; i++) rdrive(1, 2'b00, 4'(i), 1, 1);
        rdrive(1, 2'b01, 4'd4, 0, 1);
        rdrive(1, 2'b01, 4'd4, 0, 1);
        rdrive(0, 2'b00, 4'd0, 1, 0);
        check_all_zero();
        idle(4);

        // Wrap-around stream of alternating arith/shift packets.
        for (int i = 0; i < 10; i++) rdrive(1, (i % 2 == 0) ? 2'b00 : 2'b01, 4'(i), 0, 1);
        idle(6);

        // Randomized traffic with occasional stall, nop, illegal and reset.
        for (int i = 0; i < 400; i++) begin
            rdrive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 4'($urandom),
                   ($urandom_range(0, 9) < 3), ($urandom_range(0, 63) != 0));
        end

        // Drain and confirm nothing was lost.
        idle(12);
        check("drain_buffer", mq.size(), 0);
        check("drain_issue", exp_iss.size(), 0);
        check("drain_result", exp_res.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
